poly_phase_accumulator: RTL

POLY_PHASE_ACCUMULATOR -- requirements
Module: poly_phase_accumulator

---
 rtl/poly_phase_accumulator_if.sv | 27 ++
 rtl/poly_phase_accumulator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_phase_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : poly_phase_accumulator_if
// Brief    : Note command channel (valid/ready handshake) for the phase bank.
// Revision : 1.0 - initial release
// ============================================================================
interface poly_phase_accumulator_if;
    logic       note_valid_in;
    logic       note_on_in;
    logic [6:0] note_value_in;
    logic       note_ready_out;

    modport master (
        output note_valid_in,
        output note_on_in,
        output note_value_in,
        input  note_ready_out
    );

    modport slave (
        input  note_valid_in,
        input  note_on_in,
        input  note_value_in,
        output note_ready_out
    );
endinterface
`default_nettype wire

// File: rtl/poly_phase_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : poly_phase_accumulator
// Brief    : Polyphonic NCO phase bank with MIDI note-to-voice allocation.
// Revision : 1.0 - initial release
// ============================================================================
module poly_phase_accumulator #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 32,
    parameter int UPDATE_HZ  = 48000
) (
    input  wire logic                          clk_in,
    input  wire logic                          rst_n_in,
    poly_phase_accumulator_if.slave            note_if,
    input  wire logic                          sample_tick_in,
    output logic [NUM_VOICES*PHASE_W-1:0]      phase_out,
    output logic [NUM_VOICES-1:0]              voice_active_out,
    output logic                               phase_valid_out,
    output logic                               overrun_out
);
    localparam int                 c_IDX_W    = $clog2(NUM_VOICES);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_VOICES - 1);

    // Octave-5 (notes 60..71) increment; other octaves are shifts of these.
    function automatic logic [PHASE_W-1:0] base_inc(input int semi);
        real freq;
        real scale;
        logic [PHASE_W-1:0] result;
        scale = 1.0;
        for (int i = 0; i < PHASE_W; i++) scale = scale * 2.0;
        if (semi > 11) begin
            result = '0;
        end else begin
            freq   = 440.0 * (2.0 ** (real'(semi - 9) / 12.0));
            result = PHASE_W'(longint'(freq * scale / real'(UPDATE_HZ)));
        end
        return result;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_ALLOC  = 2'd2
    } cmd_state_t;

    cmd_state_t          r_state;
    cmd_state_t          w_state_nxt;
    logic                r_ready;
    logic                w_accept;
    logic                r_cmd_on;
    logic [6:0]          r_cmd_note;
    logic [6:0]          r_rem;
    logic [3:0]          r_oct;

    logic [PHASE_W-1:0]  r_phase [NUM_VOICES];
    logic [PHASE_W-1:0]  r_inc   [NUM_VOICES];
    logic [6:0]          r_note  [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_active;
    logic [c_IDX_W-1:0]  r_steal;

    logic                w_hit;
    logic                w_free;
    logic [c_IDX_W-1:0]  w_hit_idx;
    logic [c_IDX_W-1:0]  w_free_idx;
    logic [c_IDX_W-1:0]  w_target;
    logic                w_alloc_we;
    logic                w_steal;

    logic [PHASE_W-1:0]  w_base_tab [16];
    logic [PHASE_W-1:0]  w_base;
    logic [PHASE_W-1:0]  w_inc;

    logic                r_seq_busy;
    logic [c_IDX_W-1:0]  r_seq_idx;
    logic                r_valid;
    logic                r_overrun;
    logic [PHASE_W-1:0]  w_sum;

    for (genvar g = 0; g < 16; g++) begin : g_base
        localparam logic [PHASE_W-1:0] c_BASE = base_inc(g);
        assign w_base_tab[g] = c_BASE;
    end

    assign w_accept               = note_if.note_valid_in && r_ready;
    assign note_if.note_ready_out = r_ready;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_DIVIDE;
            ST_DIVIDE: if (r_rem < 7'd12) w_state_nxt = ST_ALLOC;
            ST_ALLOC:  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Repeated subtraction yields octave and semitone without a divider.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cmd_on   <= 1'b0;
            r_cmd_note <= '0;
            r_rem      <= '0;
            r_oct      <= '0;
        end else if (r_state == ST_IDLE && w_accept) begin
            r_cmd_on   <= note_if.note_on_in;
            r_cmd_note <= note_if.note_value_in;
            r_rem      <= note_if.note_value_in;
            r_oct      <= '0;
        end else if (r_state == ST_DIVIDE && r_rem >= 7'd12) begin
            r_rem <= r_rem - 7'd12;
            r_oct <= r_oct + 4'd1;
        end
    end

    assign w_base = w_base_tab[r_rem[3:0]];
    assign w_inc  = (r_oct >= 4'd5) ? (w_base << (r_oct - 4'd5))
                                    : (w_base >> (4'd5 - r_oct));

    // Descending scan so the lowest matching index is the one kept.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        w_target   = r_steal;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_active[v] && r_note[v] == r_cmd_note) begin
                w_hit     = 1'b1;
                w_hit_idx = c_IDX_W'(v);
            end
            if (!r_active[v]) begin
                w_free     = 1'b1;
                w_free_idx = c_IDX_W'(v);
            end
        end
        if (w_hit)       w_target = w_hit_idx;
        else if (w_free) w_target = w_free_idx;
        w_alloc_we = (r_state == ST_ALLOC) && (r_cmd_on || w_hit);
        w_steal    = (r_state == ST_ALLOC) && r_cmd_on && !w_hit && !w_free;
    end

    assign w_sum = r_phase[r_seq_idx] + r_inc[r_seq_idx];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_seq_busy <= 1'b0;
            r_seq_idx  <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (sample_tick_in && r_seq_busy) r_overrun <= 1'b1;
            if (r_seq_busy) begin
                if (r_seq_idx == c_LAST_IDX) begin
                    r_seq_busy <= 1'b0;
                    r_seq_idx  <= '0;
                    r_valid    <= 1'b1;
                end else begin
                    r_seq_idx <= r_seq_idx + c_IDX_W'(1);
                end
            end else if (sample_tick_in) begin
                r_seq_busy <= 1'b1;
                r_seq_idx  <= '0;
            end
        end
    end

    // A command write to the voice under visit takes priority over its accumulate.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_phase[v] <= '0;
                r_inc[v]   <= '0;
                r_note[v]  <= '0;
            end
            r_active <= '0;
            r_steal  <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_alloc_we && w_target == c_IDX_W'(v)) begin
                    r_phase[v]  <= '0;
                    r_active[v] <= r_cmd_on;
                    if (r_cmd_on) begin
                        r_inc[v]  <= w_inc;
                        r_note[v] <= r_cmd_note;
                    end
                end else if (r_seq_busy && r_seq_idx == c_IDX_W'(v) && r_active[v]) begin
                    r_phase[v] <= w_sum;
                end
            end
            if (w_steal) r_steal <= (r_steal == c_LAST_IDX) ? '0 : r_steal + c_IDX_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
        assign phase_out[g*PHASE_W +: PHASE_W] = r_phase[g];
    end

    assign voice_active_out = r_active;
    assign phase_valid_out  = r_valid;
    assign overrun_out      = r_overrun;
endmodule
`default_nettype wire
